ripple_carry_adder: RTL and testbench

- Parameterised two's-complement adder built as a structural ripple chain of 1-bit full adders, with a registered result stage.
- Produces the sum, carry-out and signed-overflow flag of A + B + Cin, one clock after the operands are accepted.
- Used as the baseline adder in the adder/multiplier datapath. Other adder architectures are compared against it bit-for-bit.

---
 rtl/ripple_carry_adder.sv | 73 +++++++
 tb/tb_ripple_carry_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: sum, carry-out and signed overflow of
// a + b + cin, one cycle after in_valid. The carry chain is a plain
// structural ripple of 1-bit full-adder cells, with no lookahead or select.

module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the raw carry-out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             raw_of;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      rca_full_adder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign raw_of = c[WIDTH] ^ c[WIDTH-1];

  // Result register: capture on in_valid, otherwise hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      of   <= 1'b0;
    end else if (in_valid) begin
      sum  <= s;
      cout <= c[WIDTH];
      of   <= raw_of;
    end
  end

  // out_valid marks a result captured on the previous edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=32). Expected results
// come from plain integer addition on 33-bit values.

module tb_ripple_carry_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         of;
  logic         out_valid;

  int passed = 0;
  int total  = 0;

  // last captured result {cout, of, sum} as the model sees it
  logic [W+1:0] last;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .of        (of),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, of, sum} of x + y + ci from arithmetic and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0]   full;
    logic         ovf;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], ovf, full[W-1:0]};
  endfunction

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    total++;
    if ({out_valid, cout, of, sum} !== {3'b000, {W{1'b0}}}) begin
      $display("FAIL reset: got v=%0b c=%0b o=%0b s=%h, want all zero",
               out_valid, cout, of, sum);
    end else passed++;
    rst = 1'b0;
    last = '0;
    tick();
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta [9];
    logic [W-1:0] tb [9];
    logic         tc [9];
    logic [W+1:0] te [9];
    ta = '{32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'h12345678, 32'hFFFFFFFF,
           32'hFFFFF999, 32'h00000420, 32'h00000123, 32'hFFFFFFFF};
    tb = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345670, 32'hFFFFFFFF,
           32'h00000111, 32'h00000420, 32'h00000123, 32'h00000000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    // {cout, of, sum} worked out by hand from the operand signs
    te = '{{2'b01, 32'hFFFFFFFE}, {2'b11, 32'h7FFFFFFF}, {2'b00, 32'h92345678},
           {2'b00, 32'h2468ACE9}, {2'b10, 32'hFFFFFFFE}, {2'b00, 32'hFFFFFAAA},
           {2'b00, 32'h00000841}, {2'b00, 32'h00000246}, {2'b10, 32'h00000000}};
    for (int i = 0; i < 9; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i]; in_valid = 1'b1;
      tick();
      total++;
      if ({out_valid, cout, of, sum} !== {1'b1, te[i]}) begin
        $display("FAIL vec%0d: got v=%0b c=%0b o=%0b s=%h, want v=1 c=%0b o=%0b s=%h",
                 i, out_valid, cout, of, sum, te[i][W+1], te[i][W], te[i][W-1:0]);
      end else passed++;
      last = te[i];
    end
    in_valid = 1'b0;
    tick();
  endtask

  // back-to-back stream with random gaps; gaps must hold the previous result
  task automatic test_back_to_back();
    logic [W+1:0] exp;
    logic         v;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b   = ($urandom_range(0, 4) == 0) ? {W{a[W-1]}} : $urandom;
      cin = $urandom_range(0, 1);
      v   = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_valid = v;
      if (v) last = model(a, b, cin);
      exp = last;
      tick();
      total++;
      if ({out_valid, cout, of, sum} !== {v, exp}) begin
        $display("FAIL b2b%0d: got v=%0b c=%0b o=%0b s=%h, want v=%0b c=%0b o=%0b s=%h",
                 i, out_valid, cout, of, sum, v, exp[W+1], exp[W], exp[W-1:0]);
      end else passed++;
    end
  endtask

  task automatic test_hold();
    a = 32'h00000001; b = 32'h00000002; cin = 1'b0; in_valid = 1'b1;
    last = model(a, b, cin);
    tick();
    a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; cin = 1'b1; in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, cout, of, sum} !== {1'b0, last}) begin
      $display("FAIL hold: got v=%0b c=%0b o=%0b s=%h, want v=0 c=%0b o=%0b s=%h",
               out_valid, cout, of, sum, last[W+1], last[W], last[W-1:0]);
    end else passed++;
    tick();
    total++;
    if ({out_valid, cout, of, sum} !== {1'b0, last}) begin
      $display("FAIL hold2: got v=%0b s=%h, want v=0 s=%h", out_valid, sum, last[W-1:0]);
    end else passed++;
  endtask

  task automatic test_async_reset();
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || sum !== 32'hFFFFFFFF) begin
      $display("FAIL async_pre: got v=%0b s=%h, want v=1 s=ffffffff", out_valid, sum);
    end else passed++;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, cout, of, sum} !== {3'b000, {W{1'b0}}}) begin
      $display("FAIL async_clr: got v=%0b c=%0b o=%0b s=%h, want all zero",
               out_valid, cout, of, sum);
    end else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({out_valid, cout, of, sum} !== {3'b000, {W{1'b0}}}) begin
      $display("FAIL async_release: got v=%0b s=%h, want v=0 s=0", out_valid, sum);
    end else passed++;
  endtask

  // operation presented during reset is dropped
  task automatic test_reset_midstream();
    a = 32'h00000005; b = 32'h00000006; cin = 1'b0; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, sum} !== {1'b0, {W{1'b0}}}) begin
      $display("FAIL drop: got v=%0b s=%h, want v=0 s=0", out_valid, sum);
    end else passed++;
    a = 32'h80000000; b = 32'h80000000; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, cout, of, sum} !== {1'b1, model(32'h80000000, 32'h80000000, 1'b0)}) begin
      $display("FAIL post_rst: got v=%0b c=%0b o=%0b s=%h, want v=1 c=1 o=1 s=0",
               out_valid, cout, of, sum);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
